// File: rtl/univ_shift_seq_pkg.sv
// Shared definitions for the multi-cycle universal shifter: op codes,
// op-field width and FSM state encoding.
package shift_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLL  = 3'd0;
    localparam logic [OP_W-1:0] OP_SRL  = 3'd1;
    localparam logic [OP_W-1:0] OP_SRA  = 3'd2;
    localparam logic [OP_W-1:0] OP_ROL  = 3'd3;
    localparam logic [OP_W-1:0] OP_ROR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SLS  = 3'd5;
    localparam logic [OP_W-1:0] OP_SRS  = 3'd6;
    localparam logic [OP_W-1:0] OP_HOLD = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/univ_shift_seq_if.sv
// Request/result bundle for univ_shift_seq; master drives requests, slave is the shifter.
interface univ_shift_seq_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) ();

    // start is sampled only while busy=0; op/amt/data_in are captured on that
    // edge. done pulses for one cycle when the result is final, and start may be
    // asserted in that same cycle for a back-to-back operation.
    logic             start;
    logic [OP_W-1:0]  op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] data_in;
    logic             ser_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic             ser_out;

    modport master (
        output start, op, amt, data_in, ser_in,
        input  data_out, busy, done, ser_out
    );

    modport slave (
        input  start, op, amt, data_in, ser_in,
        output data_out, busy, done, ser_out
    );

endinterface

// File: rtl/univ_shift_seq_step.sv
// One 1-bit step of the universal shifter: purely combinational.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in,
    output logic [WIDTH-1:0] dout,
    output logic             bit_out
);

    always_comb begin
        dout    = din;
        bit_out = din[0];
        case (op)
            OP_SLL: begin dout = {din[WIDTH-2:0], 1'b0};         bit_out = din[WIDTH-1]; end
            OP_SRL: begin dout = {1'b0, din[WIDTH-1:1]};         bit_out = din[0];       end
            OP_SRA: begin dout = {din[WIDTH-1], din[WIDTH-1:1]}; bit_out = din[0];       end
            OP_ROL: begin dout = {din[WIDTH-2:0], din[WIDTH-1]}; bit_out = din[WIDTH-1]; end
            OP_ROR: begin dout = {din[0], din[WIDTH-1:1]};       bit_out = din[0];       end
            OP_SLS: begin dout = {din[WIDTH-2:0], ser_in};       bit_out = din[WIDTH-1]; end
            OP_SRS: begin dout = {ser_in, din[WIDTH-1:1]};       bit_out = din[0];       end
            default: begin dout = din;                           bit_out = din[0];       end
        endcase
    end

endmodule

// File: rtl/univ_shift_seq.sv
// Multi-cycle universal shifter: loads a word, then applies one 1-bit step per
// clock for amt cycles, pulsing done when the result is final.
module univ_shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    univ_shift_seq_if.slave   bus,
    output state_t            state_dbg
);

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             ser_q, ser_d;
    logic [WIDTH-1:0] step_dout;
    logic             step_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .din     (data_q),
        .ser_in  (bus.ser_in),
        .dout    (step_dout),
        .bit_out (step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ser_q   <= ser_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    data_d = bus.data_in;
                    op_d   = bus.op;
                    cnt_d  = bus.amt;
                    // A zero-length request completes on the accept edge.
                    if (bus.amt == '0) done_d  = 1'b1;
                    else               state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = step_dout;
                cnt_d  = cnt_q - AMT_W'(1);
                if (op_q != OP_HOLD) ser_d = step_bit;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.data_out = data_q;
    assign bus.busy     = (state_q == ST_SHIFT);
    assign bus.done     = done_q;
    assign bus.ser_out  = ser_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Randomized bench for univ_shift_seq against an arithmetic reference model.
module tb_univ_shift_seq;
    import shift_pkg::*;

    localparam int W = 8;
    localparam int AW = $clog2(W + 1);

    logic   clk;
    logic   rst_n;
    state_t st_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ser    = 0;
    logic [W-1:0] exp_q[$];

    univ_shift_seq_if #(.WIDTH(W)) bus ();

    univ_shift_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (st_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One step computed from the op definitions with plain integer arithmetic.
    function automatic void ref_step(input int op, input int v, input int s,
                                     output int nv, output int bo);
        int mask, msb, lsb, top;
        mask = (1 << W) - 1;
        top  = 1 << (W - 1);
        msb  = (v / top) % 2;
        lsb  = v % 2;
        nv   = v;
        bo   = 0;
        case (op)
            0: begin nv = (v * 2) & mask;       bo = msb; end
            1: begin nv = v / 2;                bo = lsb; end
            2: begin nv = v / 2 + msb * top;    bo = lsb; end
            3: begin nv = ((v * 2) & mask) + msb; bo = msb; end
            4: begin nv = v / 2 + lsb * top;    bo = lsb; end
            5: begin nv = ((v * 2) & mask) + s; bo = msb; end
            6: begin nv = v / 2 + s * top;      bo = lsb; end
            default: begin nv = v;              bo = 0;   end
        endcase
    endfunction

    task automatic check_outputs(input string tag, input int v, input int bsy, input int dn);
        check_val({tag, "_data"}, bus.data_out, v);
        check_val({tag, "_ser"},  bus.ser_out, m_ser);
        check_val({tag, "_busy"}, bus.busy, bsy);
        check_val({tag, "_done"}, bus.done, dn);
    endtask

    // Driver: called at a negedge, returns at the negedge where done is high.
    // ser_mode: 0 fill 0, 1 fill 1, 2 random per step. junk_at: step with a stray start.
    task automatic run_op(input int op, input int data, input int amt,
                          input int ser_mode, input int junk_at);
        logic [15:0] sb;
        int v, nv, bo, s;
        sb = (ser_mode == 2) ? 16'($urandom) : ((ser_mode == 1) ? 16'hFFFF : 16'h0000);
        v = data;
        s = m_ser;
        for (int i = 0; i < amt; i++) begin
            ref_step(op, v, int'(sb[i]), nv, bo);
            v = nv;
            if (op != 7) s = bo;
        end
        exp_q.push_back(W'(v));

        bus.start   = 1'b1;
        bus.op      = 3'(op);
        bus.amt     = AW'(amt);
        bus.data_in = W'(data);
        bus.ser_in  = sb[0];
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = 3'($urandom);
        bus.amt     = AW'($urandom);
        bus.data_in = W'($urandom);
        v = data;
        if (amt == 0) begin
            check_outputs("accept0", v, 0, 1);
        end else begin
            check_outputs("accept", v, 1, 0);
            for (int i = 0; i < amt; i++) begin
                bus.ser_in = sb[i];
                if (junk_at == i + 1) begin
                    bus.start   = 1'b1;
                    bus.data_in = 8'h33;
                end
                ref_step(op, v, int'(sb[i]), nv, bo);
                v = nv;
                if (op != 7) m_ser = bo;
                @(negedge clk);
                bus.start = 1'b0;
                check_outputs("step", v, (i < amt - 1) ? 1 : 0, (i == amt - 1) ? 1 : 0);
            end
        end
        check_val("final", bus.data_out, exp_q.pop_front());
    endtask

    task automatic idle_cycles(input int n);
        bus.start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.amt     = '0;
        bus.data_in = '0;
        bus.ser_in  = 1'b0;
        #3;
        check_outputs("reset", 0, 0, 0);
        check_val("reset_state", st_dbg, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_op(0, 8'h0A, 1, 0, 0);
        check_val("sll_0a", bus.data_out, 8'h14);
        run_op(1, 8'h0A, 1, 0, 0);
        check_val("srl_0a", bus.data_out, 8'h05);
        run_op(2, 8'h90, 3, 0, 0);
        check_val("sra_90", bus.data_out, 8'hF2);
        run_op(3, 8'hA5, 4, 2, 0);
        check_val("rol_a5", bus.data_out, 8'h5A);
        check_val("rol_a5_ser", bus.ser_out, 1'b0);
        run_op(4, 8'h01, 9, 2, 0);
        check_val("ror9_01", bus.data_out, 8'h80);
        run_op(5, 8'h00, 8, 1, 3);
        check_val("sls_ff", bus.data_out, 8'hFF);
        run_op(6, 8'hFF, 2, 0, 0);
        check_val("srs_3f", bus.data_out, 8'h3F);
        run_op(int'($urandom_range(0, 7)), 8'h5C, 0, 2, 0);
        check_val("amt0_5c", bus.data_out, 8'h5C);
        run_op(7, 8'h77, 3, 2, 0);
        check_val("hold_77", bus.data_out, 8'h77);
        idle_cycles(1);
        check_val("done_clear", bus.done, 1'b0);

        // asynchronous reset mid-clock
        run_op(0, 8'hFF, 3, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_ser = 0;
        check_outputs("async_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset during a SHIFT aborts without a done pulse
        bus.start = 1'b1; bus.op = 3'd0; bus.amt = AW'(5); bus.data_in = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("pre_abort_busy", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("abort_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_outputs("post_abort", 0, 0, 0);
        end
        run_op(3, 8'h81, 2, 0, 0);
        check_val("after_abort", bus.data_out, 8'h06);

        // randomized traffic, with occasional idle gaps
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 15)), 2,
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 0);
        end
        idle_cycles(2);
        check_val("end_idle_busy", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
